// File: rtl/sram_like_to_axi_if.sv
// AXI3 master-side bus between the sram_like bridge and the SoC interconnect.
// Single-beat transactions only; burst/lock/cache/prot fields are carried so
// the slave side sees a complete AXI3 port.
interface sram_like_to_axi_if;
  // read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  // write data channel
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // write response channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sram_like_to_axi.sv
// Bridge from the CPU's instruction and data sram_like ports to one AXI3
// master. Data port has priority; one transaction in flight at a time, each a
// single beat. addr_ok is given combinationally in IDLE, data_ok
// combinationally on the closing R or B handshake.
module sram_like_to_axi #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction port
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // AXI3 master
  sram_like_to_axi_if.master axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic        src_reg, src_next;         // 1 = data port, 0 = instruction port
  logic [1:0]  size_reg, size_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        aw_done_reg, aw_done_next;
  logic        w_done_reg, w_done_next;

  logic        arvalid_c, rready_c, awvalid_c, wvalid_c, bready_c;
  logic [3:0]  id_c;
  logic [3:0]  wstrb_c;

  // Instruction-side writes and AXI response IDs/codes carry no information here.
  logic unused_ok;
  assign unused_ok = &{1'b0, inst_wr, inst_wdata, axi.rid, axi.rresp, axi.rlast,
                       axi.bid, axi.bresp};

  // State and transaction latches; reset drops any in-flight handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      src_reg     <= 1'b0;
      size_reg    <= 2'd0;
      addr_reg    <= 32'd0;
      wdata_reg   <= 32'd0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      src_reg     <= src_next;
      size_reg    <= size_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
    end
  end

  // Arbitration, next-state logic and per-state handshake outputs.
  always_comb begin
    state_next   = state_reg;
    src_next     = src_reg;
    size_next    = size_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    arvalid_c    = 1'b0;
    rready_c     = 1'b0;
    awvalid_c    = 1'b0;
    wvalid_c     = 1'b0;
    bready_c     = 1'b0;
    case (state_reg)
      IDLE: begin
        // acceptance is suppressed while reset is held so nothing is latched
        if (!rst) begin
          if (data_req) begin
            data_addr_ok = 1'b1;
            src_next     = 1'b1;
            size_next    = data_size;
            addr_next    = data_addr;
            wdata_next   = data_wdata;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
            state_next   = data_wr ? WR_ADDR : RD_ADDR;
          end else if (inst_req) begin
            inst_addr_ok = 1'b1;
            src_next     = 1'b0;
            size_next    = inst_size;
            addr_next    = inst_addr;
            wdata_next   = 32'd0;
            state_next   = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        arvalid_c = 1'b1;
        if (axi.arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        rready_c = 1'b1;
        if (axi.rvalid) begin
          data_data_ok = src_reg;
          inst_data_ok = ~src_reg;
          state_next   = IDLE;
        end
      end
      WR_ADDR: begin
        // AW and W complete independently; leave once both have been taken
        awvalid_c = ~aw_done_reg;
        wvalid_c  = ~w_done_reg;
        if (awvalid_c && axi.awready) aw_done_next = 1'b1;
        if (wvalid_c && axi.wready)   w_done_next  = 1'b1;
        if (aw_done_next && w_done_next) state_next = WR_RESP;
      end
      WR_RESP: begin
        bready_c = 1'b1;
        if (axi.bvalid) begin
          data_data_ok = src_reg;
          inst_data_ok = ~src_reg;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte-lane strobes from the latched size and low address bits.
  always_comb begin
    case (size_reg)
      2'd0:    wstrb_c = 4'b0001 << addr_reg[1:0];
      2'd1:    wstrb_c = addr_reg[1] ? 4'b1100 : 4'b0011;
      default: wstrb_c = 4'b1111;
    endcase
  end

  assign id_c = src_reg ? ID_DATA : ID_INST;

  assign axi.arid    = id_c;
  assign axi.araddr  = addr_reg;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = {1'b0, size_reg};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = arvalid_c;
  assign axi.rready  = rready_c;

  assign axi.awid    = id_c;
  assign axi.awaddr  = addr_reg;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = {1'b0, size_reg};
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = awvalid_c;

  assign axi.wid     = id_c;
  assign axi.wdata   = wdata_reg;
  assign axi.wstrb   = wstrb_c;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_c;
  assign axi.bready  = bready_c;

  // Read data is passed straight through; only meaningful with data_ok.
  assign inst_rdata = axi.rdata;
  assign data_rdata = axi.rdata;

endmodule

// File: tb/tb_sram_like_to_axi.sv
// Bench for sram_like_to_axi: the bench plays both CPU ports and an AXI slave
// with a small word memory. A byte-addressed reference memory tracks what the
// CPU wrote; read data returned through the bridge must match it.
module tb_sram_like_to_axi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = 2'd0;
  logic [31:0] inst_addr = 32'd0, inst_wdata = 32'd0;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = 32'd0, data_wdata = 32'd0;
  logic [31:0] data_rdata;
  logic        data_addr_ok, data_data_ok;

  sram_like_to_axi_if axi ();

  sram_like_to_axi #(.ID_INST(4'd0), .ID_DATA(4'd1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .axi(axi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] slave_mem [16];   // AXI slave storage, written via DUT strobes
  logic [7:0]  model_mem [64];   // reference, written byte by byte from CPU intent

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // drive point: just after the active edge; sample point: 3 ns later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] addr);
    int n;
    int off;
    n   = 1 << size;
    off = (int'(addr[1:0]) / n) * n;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    int b;
    b = int'(addr[5:2]) * 4;
    return {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
  endfunction

  task automatic model_write(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    int lane;
    n = 1 << size;
    for (int i = 0; i < n; i++) begin
      lane = int'(addr[1:0]) + i;
      model_mem[int'(addr[5:0]) + i] = wdata[8*lane +: 8];
    end
  endtask

  task automatic clear_axi();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
  endtask

  // One complete transaction on the chosen port. d1/d2 are AR/R delays for
  // reads, AW/W delays for writes; d3 is the B delay. other_req holds the
  // opposite port's request high throughout to check it is not accepted.
  task automatic run_txn(input bit is_data, input bit wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit other_req, input int d1, input int d2, input int d3);
    logic [3:0] exp_id;
    bit aw_pend;
    bit w_pend;
    bit aw_hs;
    bit w_hs;
    logic own_dok, oth_dok, own_aok, oth_aok;
    exp_id = is_data ? 4'd1 : 4'd0;

    // cycle 0: request presented, accepted combinationally
    cyc();
    clear_axi();
    if (is_data) begin
      data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
      inst_req = other_req;
    end else begin
      inst_req = 1'b1; inst_wr = 1'b0; inst_size = size; inst_addr = addr;
      data_req = other_req;
    end
    smp();
    own_aok = is_data ? data_addr_ok : inst_addr_ok;
    oth_aok = is_data ? inst_addr_ok : data_addr_ok;
    chk1("addr_ok", own_aok, 1'b1);
    chk1("other_addr_ok", oth_aok, 1'b0);

    // drop the request and scramble its fields: the bridge must use its latch
    cyc();
    if (is_data) begin
      data_req = 1'b0; data_addr = $urandom; data_wdata = $urandom; data_size = 2'($urandom_range(0, 2));
    end else begin
      inst_req = 1'b0; inst_addr = $urandom; inst_size = 2'($urandom_range(0, 2));
    end

    if (!wr) begin
      for (int c = 0; ; c++) begin
        if (c > 0) cyc();
        axi.arready = (c >= d1);
        smp();
        chk1("arvalid", axi.arvalid, 1'b1);
        chk("araddr", axi.araddr, addr);
        chk("arid", 32'(axi.arid), 32'(exp_id));
        chk("arsize", 32'(axi.arsize), 32'(size));
        chk1("rready_early", axi.rready, 1'b0);
        chk1("addr_ok_busy", inst_addr_ok | data_addr_ok, 1'b0);
        chk1("data_ok_early", inst_data_ok | data_data_ok, 1'b0);
        if (c >= d1) break;
      end
      cyc();
      axi.arready = 1'b0;
      for (int c = 0; ; c++) begin
        if (c > 0) cyc();
        axi.rvalid = (c >= d2);
        axi.rdata  = (c >= d2) ? slave_mem[addr[5:2]] : 32'hDEAD_BEEF;
        smp();
        own_dok = is_data ? data_data_ok : inst_data_ok;
        oth_dok = is_data ? inst_data_ok : data_data_ok;
        chk1("rready", axi.rready, 1'b1);
        chk1("arvalid_after", axi.arvalid, 1'b0);
        chk1("rd_data_ok", own_dok, (c >= d2));
        chk1("rd_other_data_ok", oth_dok, 1'b0);
        chk1("addr_ok_busy", inst_addr_ok | data_addr_ok, 1'b0);
        if (c >= d2) begin
          chk("rdata", is_data ? data_rdata : inst_rdata, model_word(addr));
          break;
        end
      end
    end else begin
      aw_pend = 1'b1;
      w_pend  = 1'b1;
      for (int c = 0; ; c++) begin
        if (c > 0) cyc();
        aw_hs = aw_pend && (c >= d1);
        w_hs  = w_pend && (c >= d2);
        axi.awready = aw_hs;
        axi.wready  = w_hs;
        smp();
        chk1("awvalid", axi.awvalid, aw_pend);
        chk1("wvalid", axi.wvalid, w_pend);
        if (aw_pend) begin
          chk("awaddr", axi.awaddr, addr);
          chk("awsize", 32'(axi.awsize), 32'(size));
          chk("awid", 32'(axi.awid), 32'(exp_id));
        end
        if (w_pend) begin
          chk("wdata", axi.wdata, wdata);
          chk("wstrb", 32'(axi.wstrb), 32'(model_strb(size, addr)));
          chk1("wlast", axi.wlast, 1'b1);
        end
        chk1("bready_early", axi.bready, 1'b0);
        chk1("data_ok_early", inst_data_ok | data_data_ok, 1'b0);
        chk1("addr_ok_busy", inst_addr_ok | data_addr_ok, 1'b0);
        if (w_hs) begin
          for (int l = 0; l < 4; l++)
            if (axi.wstrb[l]) slave_mem[addr[5:2]][8*l +: 8] = axi.wdata[8*l +: 8];
          model_write(size, addr, wdata);
        end
        if (aw_hs) aw_pend = 1'b0;
        if (w_hs)  w_pend  = 1'b0;
        if (!aw_pend && !w_pend) break;
      end
      cyc();
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      for (int c = 0; ; c++) begin
        if (c > 0) cyc();
        axi.bvalid = (c >= d3);
        smp();
        chk1("bready", axi.bready, 1'b1);
        chk1("awvalid_after", axi.awvalid | axi.wvalid, 1'b0);
        chk1("wr_data_ok", data_data_ok, (c >= d3));
        chk1("wr_inst_data_ok", inst_data_ok, 1'b0);
        chk1("addr_ok_busy", inst_addr_ok | data_addr_ok, 1'b0);
        if (c >= d3) break;
      end
    end
    $display("txn port=%s wr=%0d size=%0d addr=%h wdata=%h", is_data ? "data" : "inst", wr, size, addr, wdata);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    bit          isd;
    bit          w;
    bit          oth;

    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = $urandom;
      for (int b = 0; b < 4; b++) model_mem[i*4 + b] = slave_mem[i][8*b +: 8];
    end
    slave_mem[0] = 32'h3C08_BFAF;
    model_mem[0] = 8'hAF; model_mem[1] = 8'hBF; model_mem[2] = 8'h08; model_mem[3] = 8'h3C;
    axi.rid = 4'd0; axi.rresp = 2'd0; axi.rlast = 1'b1; axi.rdata = 32'd0;
    axi.bid = 4'd0; axi.bresp = 2'd0;
    clear_axi();

    // reset state
    cyc();
    cyc();
    smp();
    chk1("rst_arvalid", axi.arvalid, 1'b0);
    chk1("rst_awvalid", axi.awvalid, 1'b0);
    chk1("rst_wvalid", axi.wvalid, 1'b0);
    chk1("rst_rready", axi.rready, 1'b0);
    chk1("rst_bready", axi.bready, 1'b0);
    chk1("rst_addr_ok", inst_addr_ok | data_addr_ok, 1'b0);
    chk1("rst_data_ok", inst_data_ok | data_data_ok, 1'b0);
    chk("rst_araddr", axi.araddr, 32'd0);
    chk("tie_arlen", 32'(axi.arlen), 32'd0);
    chk("tie_awlen", 32'(axi.awlen), 32'd0);
    chk("tie_burst", 32'({axi.arburst, axi.awburst}), 32'h5);
    chk("tie_misc", 32'({axi.arlock, axi.awlock, axi.arcache, axi.awcache, axi.arprot, axi.awprot}), 32'd0);
    chk1("tie_wlast", axi.wlast, 1'b1);
    rst = 1'b0;

    // boot fetch: addr_ok cycle 0, arvalid cycle 1, data_ok cycle 2
    run_txn(1'b0, 1'b0, 2'd2, 32'h1FC0_0000, 32'd0, 1'b0, 0, 0, 0);
    chk("boot_word", inst_rdata, 32'h3C08_BFAF);

    // simultaneous requests: data first, instruction on the next IDLE
    inst_addr = 32'h0000_0020; inst_size = 2'd2;
    run_txn(1'b1, 1'b0, 2'd2, 32'h0000_1004, 32'd0, 1'b1, 0, 1, 0);
    run_txn(1'b0, 1'b0, 2'd2, 32'h0000_0020, 32'd0, 1'b0, 0, 0, 0);

    // byte write, AW accepted two cycles before W
    run_txn(1'b1, 1'b1, 2'd0, 32'h0000_0003, 32'hAB00_0000, 1'b0, 0, 2, 1);
    // half writes on both halves, AW and W together
    run_txn(1'b1, 1'b1, 2'd1, 32'h0000_0002, 32'h1234_0000, 1'b0, 0, 0, 0);
    run_txn(1'b1, 1'b1, 2'd1, 32'h0000_0000, 32'h0000_5678, 1'b0, 0, 0, 0);
    // word write, W before AW
    run_txn(1'b1, 1'b1, 2'd2, 32'h0000_0008, 32'hCAFE_F00D, 1'b0, 3, 1, 2);
    // read back merged bytes
    run_txn(1'b1, 1'b0, 2'd2, 32'h0000_0000, 32'd0, 1'b0, 0, 0, 0);
    run_txn(1'b1, 1'b0, 2'd2, 32'h0000_0008, 32'd0, 1'b0, 1, 2, 0);

    // arready held off for 5 cycles with a competing instruction request
    inst_addr = 32'h0000_0030; inst_size = 2'd2;
    run_txn(1'b1, 1'b0, 2'd2, 32'h0000_0014, 32'd0, 1'b1, 5, 0, 0);
    run_txn(1'b0, 1'b0, 2'd2, 32'h0000_0030, 32'd0, 1'b0, 0, 0, 0);

    // reset while waiting in the read-data phase
    cyc();
    clear_axi();
    inst_req = 1'b1; inst_addr = 32'h0000_0010; inst_size = 2'd2;
    smp();
    chk1("rr_addr_ok", inst_addr_ok, 1'b1);
    cyc();
    inst_req = 1'b0;
    axi.arready = 1'b1;
    smp();
    chk1("rr_arvalid", axi.arvalid, 1'b1);
    cyc();
    axi.arready = 1'b0;
    smp();
    chk1("rr_rready", axi.rready, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    axi.rvalid = 1'b1;
    axi.rdata  = 32'h0BAD_0BAD;
    smp();
    chk1("rr_post_rready", axi.rready, 1'b0);
    chk1("rr_post_data_ok", inst_data_ok | data_data_ok, 1'b0);
    chk1("rr_post_arvalid", axi.arvalid, 1'b0);
    $display("reset during RD_DATA applied");
    run_txn(1'b0, 1'b0, 2'd2, 32'h0000_0010, 32'd0, 1'b0, 0, 0, 0);

    // randomized traffic against the byte-level reference memory
    for (int t = 0; t < 40; t++) begin
      isd = 1'($urandom_range(0, 1));
      w   = isd ? 1'($urandom_range(0, 1)) : 1'b0;
      sz  = 2'($urandom_range(0, 2));
      a   = $urandom;
      a   = (a & 32'hFFFF_FFC0) | (32'($urandom_range(0, 63)) & ~((32'd1 << sz) - 32'd1));
      oth = isd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (oth) begin
        inst_addr = $urandom;
        inst_size = 2'd2;
      end
      run_txn(isd, w, sz, a, $urandom, oth,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    cyc();
    inst_req = 1'b0;
    data_req = 1'b0;
    clear_axi();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
